// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with leading-zero blank mask
module bin2bcd_seq #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    // Idle display shows a single "0": every digit dark except the units digit.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [IN_WIDTH-1:0]   sreg;
    logic [BW-1:0]         scratch;
    logic [BW-1:0]         adj;
    logic                  ovf_s;
    logic [CW-1:0]         cnt;
    logic [DIGITS-1:0]     blank_nxt;
    logic                  zero_above;

    // Add-3 correction on every scratch digit >= 5, digits independent (no carry between nibbles).
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask: a digit is blanked when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above & (scratch[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_above;
        end
    end

    // Conversion FSM: capture in IDLE, one shift per input bit, publish results in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
            sreg     <= '0;
            scratch  <= '0;
            ovf_s    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= bin_in;
                        scratch <= '0;
                        ovf_s   <= 1'b0;
                        cnt     <= CW'(IN_WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A bit pushed out of the top digit means the value does not fit in DIGITS digits.
                    ovf_s   <= ovf_s | adj[BW-1];
                    scratch <= {adj[BW-2:0], sreg[IN_WIDTH-1]};
                    sreg    <= {sreg[IN_WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out  <= scratch;
                    overflow <= ovf_s;
                    blank    <= blank_nxt;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq against an arithmetic model
module tb_bin2bcd_seq;

    localparam int W  = 16;
    localparam int D  = 5;
    localparam int WS = 10;
    localparam int DS = 3;

    logic            clock   = 1'b0;
    logic            reset   = 1'b1;
    logic            start   = 1'b0;
    logic [W-1:0]    bin_in  = '0;
    logic            busy, done, overflow;
    logic [4*D-1:0]  bcd_out;
    logic [D-1:0]    blank;

    logic            start_s = 1'b0;
    logic [WS-1:0]   bin_s   = '0;
    logic            busy_s, done_s, overflow_s;
    logic [4*DS-1:0] bcd_s;
    logic [DS-1:0]   blank_s;

    bin2bcd_seq #(.IN_WIDTH(W), .DIGITS(D)) dut (
        .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank), .overflow(overflow)
    );

    bin2bcd_seq #(.IN_WIDTH(WS), .DIGITS(DS)) dut_s (
        .clock(clock), .reset(reset), .start(start_s), .bin_in(bin_s),
        .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .blank(blank_s), .overflow(overflow_s)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal result from plain arithmetic: value mod 10^nd, overflow when value >= 10^nd,
    // digit k is a leading zero exactly when the shown value is below 10^k.
    function automatic void conv(input longint v, input int nd,
                                 output logic [39:0] bcd, output logic [9:0] blk, output logic ovf);
        longint p = 1;
        longint r;
        longint pk = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        ovf = (v >= p);
        r   = v % p;
        bcd = '0;
        blk = '0;
        for (int k = 0; k < nd; k++) begin
            bcd[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        for (int k = 1; k < nd; k++) begin
            pk = pk * 10;
            blk[k] = ((v % p) < pk);
        end
    endfunction

    // Reference model: an accepted start produces a result IN_WIDTH+1 clocks later; starts while busy are dropped.
    int             m_rem   = 0;
    logic           m_done  = 1'b0;
    logic           m_ovf   = 1'b0;
    logic [4*D-1:0] m_bcd   = '0;
    logic [D-1:0]   m_blank = ~(D'(1));
    longint         m_val   = 0;

    always @(posedge clock or posedge reset) begin
        logic [39:0] b;
        logic [9:0]  bl;
        logic        o;
        if (reset) begin
            m_rem   = 0;
            m_done  = 1'b0;
            m_bcd   = '0;
            m_ovf   = 1'b0;
            m_blank = ~(D'(1));
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    conv(m_val, D, b, bl, o);
                    m_bcd   = b[4*D-1:0];
                    m_blank = bl[D-1:0];
                    m_ovf   = o;
                    m_done  = 1'b1;
                end
            end else if (start) begin
                m_val = longint'(bin_in);
                m_rem = W + 1;
            end
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("busy", 64'(busy), 64'(m_rem > 0));
            check("done", 64'(done), 64'(m_done));
            check("bcd_out", 64'(bcd_out), 64'(m_bcd));
            check("blank", 64'(blank), 64'(m_blank));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // Called at a negedge: present start for the next rising edge, then drop it.
    task automatic start_conv(input logic [W-1:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clock);
        start  = 1'b0;
        bin_in = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 60);
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic small_conv(input logic [WS-1:0] v, output int n);
        start_s = 1'b1;
        bin_s   = v;
        @(negedge clock);
        start_s = 1'b0;
        bin_s   = WS'($urandom);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done_s && n < 60);
        check("small_done_seen", 64'(done_s), 64'd1);
    endtask

    initial begin
        int n;
        logic [W-1:0] v;
        logic [WS-1:0] vs;
        logic [39:0] eb;
        logic [9:0]  ebl;
        logic        eo;

        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_blank", 64'(blank), 64'b11110);
        check("rst_ovf", 64'(overflow), 64'd0);

        start_conv(16'd0);
        wait_done(n);
        check("lat_zero", 64'(n), 64'd17);
        check("zero_bcd", 64'(bcd_out), 64'h00000);
        check("zero_blank", 64'(blank), 64'b11110);
        check("zero_ovf", 64'(overflow), 64'd0);

        @(negedge clock);
        start_conv(16'd65535);
        wait_done(n);
        check("lat_max", 64'(n), 64'd17);
        check("max_bcd", 64'(bcd_out), 64'h65535);
        check("max_blank", 64'(blank), 64'b00000);
        check("max_ovf", 64'(overflow), 64'd0);

        @(negedge clock);
        start_conv(16'd1234);
        repeat (7) @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd5;
        @(negedge clock);
        start  = 1'b0;
        wait_done(n);
        check("lat_after_ignored", 64'(n), 64'd9);
        check("b1234_bcd", 64'(bcd_out), 64'h01234);
        check("b1234_blank", 64'(blank), 64'b10000);
        start_conv(16'd5);
        wait_done(n);
        check("lat_back_to_back", 64'(n), 64'd17);
        check("b5_bcd", 64'(bcd_out), 64'h00005);

        @(negedge clock);
        start_conv(16'd9);
        wait_done(n);
        check("b9_bcd", 64'(bcd_out), 64'h00009);
        check("b9_blank", 64'(blank), 64'b11110);

        small_conv(10'd1000, n);
        check("small_lat", 64'(n), 64'd11);
        check("small_1000_bcd", 64'(bcd_s), 64'h000);
        check("small_1000_ovf", 64'(overflow_s), 64'd1);
        check("small_1000_blank", 64'(blank_s), 64'b110);
        small_conv(10'd999, n);
        check("small_999_bcd", 64'(bcd_s), 64'h999);
        check("small_999_ovf", 64'(overflow_s), 64'd0);
        check("small_999_blank", 64'(blank_s), 64'b000);
        for (int i = 0; i < 6; i++) begin
            vs = WS'($urandom);
            small_conv(vs, n);
            conv(longint'(vs), DS, eb, ebl, eo);
            check("small_rand_bcd", 64'(bcd_s), 64'(eb[4*DS-1:0]));
            check("small_rand_blank", 64'(blank_s), 64'(ebl[DS-1:0]));
            check("small_rand_ovf", 64'(overflow_s), 64'(eo));
        end

        // Random values, random idle gaps, and start/bin_in noise while the converter is busy.
        for (int i = 0; i < 40; i++) begin
            case (i % 8)
                0:       v = 16'd0;
                1:       v = 16'd65535;
                2:       v = 16'd9999;
                3:       v = 16'd10000;
                default: v = W'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clock);
            start_conv(v);
            n = 0;
            do begin
                @(negedge clock);
                n++;
                if (!done) begin
                    start  = 1'($urandom_range(0, 1));
                    bin_in = W'($urandom);
                end else begin
                    start  = 1'b0;
                end
            end while (!done && n < 60);
            check("rand_lat", 64'(n), 64'd17);
        end

        // Reset mid-conversion: outputs return to reset values at once and no done follows.
        @(negedge clock);
        start_conv(16'd65535);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd_out), 64'd0);
        check("abort_blank", 64'(blank), 64'b11110);
        check("abort_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            check("abort_no_done", 64'(done), 64'd0);
        end
        start_conv(16'd42);
        wait_done(n);
        check("b42_bcd", 64'(bcd_out), 64'h00042);
        check("b42_blank", 64'(blank), 64'b11100);
        check("b42_ovf", 64'(overflow), 64'd0);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
